// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC and the IF/ID register, issues I-cache requests,
// and handles stall, branch redirect, outstanding-miss drain and HLT.
module if_fetch_ctrl #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0000,
    parameter logic [3:0]  HLT_OPC   = 4'b1111
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [15:0] imem_data,
    input  logic        stall,
    input  logic        flush,
    input  logic [15:0] branch_target,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc_plus2,
    output logic        ifid_valid,
    output logic        fetch_miss,
    output logic        halted
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      state_reg;
    logic [15:0] pc_reg;
    logic [15:0] redirect_pc_reg;
    logic [15:0] target_aligned;
    logic [15:0] pc_plus2;

    assign target_aligned = {branch_target[15:1], 1'b0};
    assign pc_plus2       = pc_reg + 16'd2;

    assign imem_req   = (state_reg != HALT) && !rst;
    assign imem_addr  = pc_reg;
    assign fetch_miss = imem_req && !imem_rdy;

    // A stall freezes everything, including a flush: the branch in ID is not yet resolved.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= FETCH;
            pc_reg          <= RESET_PC;
            redirect_pc_reg <= 16'h0000;
            ifid_instr      <= NOP_INSTR;
            ifid_pc_plus2   <= 16'h0000;
            ifid_valid      <= 1'b0;
            halted          <= 1'b0;
        end else if (!stall) begin
            case (state_reg)
                FETCH: begin
                    if (flush) begin
                        ifid_instr <= NOP_INSTR;
                        ifid_valid <= 1'b0;
                        if (imem_rdy) begin
                            pc_reg <= target_aligned;
                        end else begin
                            // The outstanding miss must complete before the target can be fetched.
                            redirect_pc_reg <= target_aligned;
                            state_reg       <= DRAIN;
                        end
                    end else if (imem_rdy) begin
                        ifid_instr    <= imem_data;
                        ifid_pc_plus2 <= pc_plus2;
                        ifid_valid    <= 1'b1;
                        if (imem_data[15:12] == HLT_OPC) begin
                            state_reg <= HALT;
                            halted    <= 1'b1;
                        end else begin
                            pc_reg <= pc_plus2;
                        end
                    end else begin
                        ifid_instr <= NOP_INSTR;
                        ifid_valid <= 1'b0;
                    end
                end
                DRAIN: begin
                    ifid_instr <= NOP_INSTR;
                    ifid_valid <= 1'b0;
                    if (flush) begin
                        redirect_pc_reg <= target_aligned;
                    end
                    if (imem_rdy) begin
                        pc_reg    <= flush ? target_aligned : redirect_pc_reg;
                        state_reg <= FETCH;
                    end
                end
                HALT: begin
                    ifid_instr <= NOP_INSTR;
                    ifid_valid <= 1'b0;
                    if (flush) begin
                        pc_reg    <= target_aligned;
                        halted    <= 1'b0;
                        state_reg <= FETCH;
                    end
                end
                default: begin
                    state_reg <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl: a cycle model checked every negedge plus literal spot checks.
module tb_if_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rdy = 1'b0;
    logic [15:0] imem_data;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc_plus2;
    logic        ifid_valid;
    logic        fetch_miss;
    logic        halted;

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;
    logic hlt_en = 1'b1;

    if_fetch_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdy      (imem_rdy),
        .imem_data     (imem_data),
        .stall         (stall),
        .flush         (flush),
        .branch_target (branch_target),
        .ifid_instr    (ifid_instr),
        .ifid_pc_plus2 (ifid_pc_plus2),
        .ifid_valid    (ifid_valid),
        .fetch_miss    (fetch_miss),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    // Instruction memory contents: opcode 1 everywhere, except a HLT at 0xFFFE when enabled.
    function automatic logic [15:0] mem(input logic [15:0] a, input logic h);
        return (h && a == 16'hFFFE) ? 16'hF123 : {4'h1, a[11:0]};
    endfunction

    always_comb imem_data = mem(imem_addr, hlt_en);

    // Behavioural model: where fetch points, whether a redirect waits on a miss, whether halted.
    logic [15:0] m_pc, m_wait_tgt, m_instr, m_pp2;
    logic        m_waiting, m_halt, m_valid;

    always @(posedge clk or posedge rst) begin
        logic [15:0] tgt;
        logic [15:0] d;
        if (rst) begin
            m_pc = 16'h0000; m_wait_tgt = 16'h0000; m_waiting = 1'b0; m_halt = 1'b0;
            m_instr = 16'h0000; m_pp2 = 16'h0000; m_valid = 1'b0;
        end else if (!stall) begin
            tgt = branch_target & 16'hFFFE;
            d   = mem(m_pc, hlt_en);
            m_instr = 16'h0000;
            m_valid = 1'b0;
            if (m_halt) begin
                if (flush) begin m_pc = tgt; m_halt = 1'b0; end
            end else if (m_waiting) begin
                if (flush) m_wait_tgt = tgt;
                if (imem_rdy) begin m_pc = m_wait_tgt; m_waiting = 1'b0; end
            end else if (flush) begin
                if (imem_rdy) m_pc = tgt;
                else begin m_wait_tgt = tgt; m_waiting = 1'b1; end
            end else if (imem_rdy) begin
                m_instr = d; m_valid = 1'b1; m_pp2 = m_pc + 16'd2;
                if (d[15:12] == 4'hF) m_halt = 1'b1;
                else m_pc = m_pc + 16'd2;
            end
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_req", {15'd0, imem_req}, {15'd0, !rst && !m_halt});
            check("cyc_addr", imem_addr, m_pc);
            check("cyc_miss", {15'd0, fetch_miss}, {15'd0, !rst && !m_halt && !imem_rdy});
            check("cyc_halted", {15'd0, halted}, {15'd0, m_halt});
            check("cyc_valid", {15'd0, ifid_valid}, {15'd0, m_valid});
            check("cyc_instr", ifid_instr, m_instr);
            if (m_valid) check("cyc_pp2", ifid_pc_plus2, m_pp2);
        end
    end

    task automatic cyc(input logic r, input logic s, input logic f, input logic [15:0] bt);
        imem_rdy = r; stall = s; flush = f; branch_target = bt;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        check("rst_req", {15'd0, imem_req}, 16'd0);
        check("rst_valid", {15'd0, ifid_valid}, 16'd0);
        check("rst_halted", {15'd0, halted}, 16'd0);
        check("rst_addr", imem_addr, 16'h0000);
        check("rst_instr", ifid_instr, 16'h0000);
        rst = 1'b0;
        #1 check("first_req", {15'd0, imem_req}, 16'd1);

        // Back-to-back hits at 0..6
        for (int k = 0; k < 4; k++) begin
            cyc(1, 0, 0, 0);
            check("hit_pp2", ifid_pc_plus2, 16'(2 * (k + 1)));
            check("hit_valid", {15'd0, ifid_valid}, 16'd1);
        end

        // Three-cycle miss at 0x0008
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 0, 0);
            check("miss_addr", imem_addr, 16'h0008);
            check("miss_bubble", {15'd0, ifid_valid}, 16'd0);
        end
        cyc(1, 0, 0, 0);
        check("miss_pp2", ifid_pc_plus2, 16'h000A);
        check("miss_instr", ifid_instr, 16'h1008);

        // Two-cycle stall with data ready: nothing moves
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        check("stall_pp2", ifid_pc_plus2, 16'h000A);
        check("stall_addr", imem_addr, 16'h000A);
        cyc(1, 0, 0, 0);
        check("refetch_instr", ifid_instr, 16'h100A);

        // Flush on a hit with odd target
        cyc(1, 0, 1, 16'h0041);
        check("flush_bubble", {15'd0, ifid_valid}, 16'd0);
        check("flush_addr", imem_addr, 16'h0040);
        cyc(1, 0, 0, 0);
        check("flush_tgt_pp2", ifid_pc_plus2, 16'h0042);

        // Flush during a miss -> drain, stale data dropped, then target
        cyc(1, 0, 1, 16'h0010);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 16'h0100);
        check("drain_addr", imem_addr, 16'h0010);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        check("drain_drop", {15'd0, ifid_valid}, 16'd0);
        check("drain_newaddr", imem_addr, 16'h0100);
        cyc(1, 0, 0, 0);
        check("drain_tgt_instr", ifid_instr, 16'h1100);

        // HLT at 0xFFFE
        cyc(1, 0, 1, 16'hFFFF);
        cyc(1, 0, 0, 0);
        check("hlt_halted", {15'd0, halted}, 16'd1);
        check("hlt_req", {15'd0, imem_req}, 16'd0);
        check("hlt_addr", imem_addr, 16'hFFFE);
        check("hlt_instr", ifid_instr, 16'hF123);
        cyc(1, 0, 0, 0);
        cyc(0, 1, 1, 16'h0000);
        check("hlt_stall_flush", {15'd0, halted}, 16'd1);
        cyc(0, 0, 1, 16'h0000);
        check("unhalt", {15'd0, halted}, 16'd0);
        check("unhalt_addr", imem_addr, 16'h0000);

        // Non-HLT at 0xFFFE wraps
        hlt_en = 1'b0;
        cyc(1, 0, 1, 16'hFFFE);
        cyc(1, 0, 0, 0);
        check("wrap_pp2", ifid_pc_plus2, 16'h0000);
        check("wrap_addr", imem_addr, 16'h0000);

        // Reset while draining loses the redirect
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 16'h0200);
        rst = 1'b1;
        #2 check("rst_mid_req", {15'd0, imem_req}, 16'd0);
        check("rst_mid_addr", imem_addr, 16'h0000);
        @(posedge clk); #1;
        rst = 1'b0;
        cyc(1, 0, 0, 0);
        check("rst_restart_pp2", ifid_pc_plus2, 16'h0002);
        cyc(0, 0, 0, 0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
